// File: rtl/lc3b_fetch_stage_pkg.sv
// Shared types for the LC-3b instruction-fetch stage: the IF/ID payload and the fetch FSM states.
package lc3b_fetch_stage_pkg;
  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word pc_plus2;
    lc3b_word ir;
  } lc3b_if_id;

  typedef enum bit [1:0] {if_fetch, if_drain, if_hold} lc3b_fetch_state;

  function automatic lc3b_word word_align(lc3b_word a);
    return {a[15:1], 1'b0};
  endfunction
endpackage

// File: rtl/lc3b_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory read handshake, decode-side hand-off and redirect.
interface lc3b_fetch_stage_if;
  import lc3b_fetch_stage_pkg::*;

  logic     imem_read;
  lc3b_word imem_address;
  logic     imem_resp;
  lc3b_word imem_rdata;
  logic     stall_in;
  logic     redirect;
  lc3b_word redirect_pc;
  logic     if_valid;
  lc3b_word if_ir;
  lc3b_word if_pc;
  lc3b_word if_pc_plus2;

  modport master (
    output imem_read, imem_address, if_valid, if_ir, if_pc, if_pc_plus2,
    input  imem_resp, imem_rdata, stall_in, redirect, redirect_pc
  );

  modport slave (
    input  imem_read, imem_address, if_valid, if_ir, if_pc, if_pc_plus2,
    output imem_resp, imem_rdata, stall_in, redirect, redirect_pc
  );
endinterface

// File: rtl/lc3b_fetch_stage_skid.sv
// One-entry skid buffer holding a fetched instruction while decode is stalled.
module lc3b_fetch_skid
  import lc3b_fetch_stage_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load,
  input  logic      flush,
  input  lc3b_if_id din,
  output logic      valid,
  output lc3b_if_id dout
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end
  end
endmodule

// File: rtl/lc3b_fetch_stage.sv
// LC-3b IF stage: owns the PC, runs the imem read handshake, absorbs decode stalls
// with a skid entry and drains any in-flight read after a redirect.
module lc3b_fetch_stage
  import lc3b_fetch_stage_pkg::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic clk,
  input  logic reset,
  lc3b_fetch_stage_if.master bus
);
  lc3b_fetch_state state_q, state_d;
  lc3b_word        pc_q, pc_d;
  lc3b_word        stale_q, stale_d;
  lc3b_if_id       slot_q, slot_d;
  logic            valid_q, valid_d;
  logic            skid_load, skid_flush, skid_valid;
  lc3b_if_id       skid_q;

  lc3b_word  pc_plus2;
  lc3b_if_id fetched;
  logic      consume, slot_free;

  assign pc_plus2  = pc_q + 16'd2;
  assign fetched   = {pc_q, pc_plus2, bus.imem_rdata};
  assign consume   = valid_q & ~bus.stall_in;
  assign slot_free = ~valid_q | consume;

  lc3b_fetch_skid u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .flush (skid_flush),
    .din   (fetched),
    .valid (skid_valid),
    .dout  (skid_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= if_fetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    stale_d    = stale_q;
    slot_d     = slot_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_flush = 1'b0;
    if (bus.redirect) begin
      // A read already on the bus must complete; its address is parked in stale_q.
      valid_d    = 1'b0;
      skid_flush = 1'b1;
      pc_d       = word_align(bus.redirect_pc);
      case (state_q)
        if_fetch: if (!bus.imem_resp) begin
          stale_d = pc_q;
          state_d = if_drain;
        end
        if_drain: if (bus.imem_resp) state_d = if_fetch;
        default:  state_d = if_fetch;
      endcase
    end else begin
      if (consume) valid_d = 1'b0;
      case (state_q)
        if_fetch: if (bus.imem_resp) begin
          pc_d = pc_plus2;
          if (slot_free) begin
            slot_d  = fetched;
            valid_d = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = if_hold;
          end
        end
        if_hold: if (consume) begin
          if (skid_valid) begin
            slot_d  = skid_q;
            valid_d = 1'b1;
          end
          skid_flush = 1'b1;
          state_d    = if_fetch;
        end
        if_drain: if (bus.imem_resp) state_d = if_fetch;
        default:  state_d = if_fetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= word_align(RESET_PC);
      stale_q <= '0;
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      stale_q <= stale_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_read    = ~reset & (state_q != if_hold);
  assign bus.imem_address = (state_q == if_drain) ? stale_q : pc_q;
  assign bus.if_valid     = valid_q;
  assign bus.if_ir        = slot_q.ir;
  assign bus.if_pc        = slot_q.pc;
  assign bus.if_pc_plus2  = slot_q.pc_plus2;
endmodule

// File: tb/tb_lc3b_fetch_stage.sv
// Bench for lc3b_fetch_stage: cycle vector table plus an in-order scoreboard of delivered instructions.
module tb_lc3b_fetch_stage;
  import lc3b_fetch_stage_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lc3b_fetch_stage_if bus ();
  lc3b_fetch_stage_if bus2 ();

  lc3b_fetch_stage #(.RESET_PC(16'h0000)) dut  (.clk(clk), .reset(reset), .bus(bus));
  lc3b_fetch_stage #(.RESET_PC(16'hFFFE)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    bit          rst;
    bit          resp;
    bit          stall;
    bit          redir;
    logic [15:0] rpc;
    bit          push;
    bit          e_read;
    logic [15:0] e_addr;
    bit          e_valid;
    logic [15:0] e_pc;
  } vec_t;

  vec_t      tbl[$];
  lc3b_if_id sb[$];
  int        vecs = 0;
  int        miss = 0;

  function automatic lc3b_word mem_word(lc3b_word a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic add(input bit rst, resp, stall, redir, input logic [15:0] rpc, input bit push,
                     input bit e_read, input logic [15:0] e_addr, input bit e_valid,
                     input logic [15:0] e_pc);
    vec_t v;
    v.rst = rst; v.resp = resp; v.stall = stall; v.redir = redir; v.rpc = rpc; v.push = push;
    v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.imem_resp = 1'b0;  bus.imem_rdata = '0;  bus.stall_in = 1'b0;
    bus.redirect = 1'b0;   bus.redirect_pc = '0;
    bus2.imem_resp = 1'b0; bus2.imem_rdata = '0; bus2.stall_in = 1'b0;
    bus2.redirect = 1'b0;  bus2.redirect_pc = '0;
  endtask

  // A response while no read is requested (i.e. in HOLD) is a protocol violation.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.imem_resp && !bus.imem_read)) else $error("imem_resp without imem_read (dut)");
      assert (!(bus2.imem_resp && !bus2.imem_read)) else $error("imem_resp without imem_read (dut2)");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    lc3b_if_id e;
    clear_inputs();

    // basic streaming, resp one cycle after each request
    add(1,0,0,0,16'h0,0, 1,16'h0000,0,16'h0);
    add(0,1,0,0,16'h0,1, 1,16'h0000,0,16'h0);
    add(0,0,0,0,16'h0,0, 1,16'h0002,1,16'h0000);
    add(0,1,0,0,16'h0,1, 1,16'h0002,0,16'h0);
    add(0,0,0,0,16'h0,0, 1,16'h0004,1,16'h0002);
    add(0,1,0,0,16'h0,1, 1,16'h0004,0,16'h0);
    add(0,0,0,0,16'h0,0, 1,16'h0006,1,16'h0004);
    // stall with slot full: second word lands in skid, HOLD until released
    add(1,1,0,0,16'h0,1, 1,16'h0000,0,16'h0);
    add(0,1,1,0,16'h0,1, 1,16'h0002,1,16'h0000);
    add(0,0,1,0,16'h0,0, 0,16'h0004,1,16'h0000);
    add(0,0,0,0,16'h0,0, 0,16'h0004,1,16'h0000);
    add(0,0,0,0,16'h0,0, 1,16'h0004,1,16'h0002);
    add(0,0,0,0,16'h0,0, 1,16'h0004,0,16'h0);
    // redirect to 0x3001 while read of 0x0004 outstanding, resp 3 cycles later
    add(1,0,0,0,16'h0,0, 1,16'h0000,0,16'h0);
    add(0,1,0,0,16'h0,1, 1,16'h0000,0,16'h0);
    add(0,0,0,0,16'h0,0, 1,16'h0002,1,16'h0000);
    add(0,1,0,0,16'h0,1, 1,16'h0002,0,16'h0);
    add(0,0,0,0,16'h0,0, 1,16'h0004,1,16'h0002);
    add(0,0,0,1,16'h3001,0, 1,16'h0004,0,16'h0);
    add(0,0,0,0,16'h0,0, 1,16'h0004,0,16'h0);
    add(0,0,0,0,16'h0,0, 1,16'h0004,0,16'h0);
    add(0,1,0,0,16'h0,0, 1,16'h0004,0,16'h0);
    add(0,0,0,0,16'h0,0, 1,16'h3000,0,16'h0);
    add(0,1,0,0,16'h0,1, 1,16'h3000,0,16'h0);
    add(0,0,0,0,16'h0,0, 1,16'h3002,1,16'h3000);
    // redirect in the same cycle as resp
    add(1,1,0,1,16'h1000,0, 1,16'h0000,0,16'h0);
    add(0,1,0,0,16'h0,1, 1,16'h1000,0,16'h0);
    add(0,0,0,0,16'h0,0, 1,16'h1002,1,16'h1000);
    // two redirects during one drain
    add(1,0,0,1,16'h2000,0, 1,16'h0000,0,16'h0);
    add(0,0,0,1,16'h4000,0, 1,16'h0000,0,16'h0);
    add(0,1,0,0,16'h0,0, 1,16'h0000,0,16'h0);
    add(0,1,0,0,16'h0,1, 1,16'h4000,0,16'h0);
    add(0,0,0,0,16'h0,0, 1,16'h4002,1,16'h4000);

    foreach (tbl[i]) begin
      @(negedge clk);
      if (tbl[i].rst) begin
        reset = 1'b1;
        clear_inputs();
        chk("sb_leftover", 16'(sb.size()), 16'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
      end
      #1;
      chk($sformatf("v%0d_imem_read", i), {15'b0, bus.imem_read}, {15'b0, tbl[i].e_read});
      chk($sformatf("v%0d_imem_address", i), bus.imem_address, tbl[i].e_addr);
      chk($sformatf("v%0d_if_valid", i), {15'b0, bus.if_valid}, {15'b0, tbl[i].e_valid});
      if (tbl[i].e_valid) chk($sformatf("v%0d_if_pc", i), bus.if_pc, tbl[i].e_pc);

      bus.imem_resp   = tbl[i].resp;
      bus.imem_rdata  = tbl[i].resp ? mem_word(bus.imem_address) : 16'hDEAD;
      bus.stall_in    = tbl[i].stall;
      bus.redirect    = tbl[i].redir;
      bus.redirect_pc = tbl[i].rpc;
      if (tbl[i].push)
        sb.push_back({bus.imem_address, bus.imem_address + 16'd2, mem_word(bus.imem_address)});

      if (bus.if_valid && !bus.stall_in) begin
        if (sb.size() == 0) begin
          vecs++; miss++;
          $display("FAIL sb_underflow: delivered pc %h, expected nothing", bus.if_pc);
        end else begin
          e = sb.pop_front();
          chk("sb_pc", bus.if_pc, e.pc);
          chk("sb_pc_plus2", bus.if_pc_plus2, e.pc_plus2);
          chk("sb_ir", bus.if_ir, e.ir);
        end
      end
    end
    @(negedge clk);
    clear_inputs();
    chk("sb_leftover_end", 16'(sb.size()), 16'd0);

    // reset pulsed mid-read drops imem_read immediately and clears the slot
    #1;
    chk("pre_reset_read", {15'b0, bus.imem_read}, 16'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_reset_read", {15'b0, bus.imem_read}, 16'd0);
    chk("mid_reset_read2", {15'b0, bus2.imem_read}, 16'd0);
    chk("mid_reset_valid", {15'b0, bus.if_valid}, 16'd0);
    chk("mid_reset_pc", bus.if_pc, 16'h0000);
    chk("mid_reset_ir", bus.if_ir, 16'h0000);
    chk("mid_reset_pc_plus2", bus.if_pc_plus2, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // RESET_PC=0xFFFE: PC wraps to 0x0000
    #1;
    chk("wrap_first_addr", bus2.imem_address, 16'hFFFE);
    chk("wrap_first_read", {15'b0, bus2.imem_read}, 16'd1);
    bus2.imem_resp  = 1'b1;
    bus2.imem_rdata = 16'h1234;
    @(negedge clk);
    bus2.imem_resp = 1'b0;
    #1;
    chk("wrap_valid", {15'b0, bus2.if_valid}, 16'd1);
    chk("wrap_if_pc", bus2.if_pc, 16'hFFFE);
    chk("wrap_if_pc_plus2", bus2.if_pc_plus2, 16'h0000);
    chk("wrap_if_ir", bus2.if_ir, 16'h1234);
    chk("wrap_second_addr", bus2.imem_address, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
